// File: rtl/fetch_stage_if.sv
// fetch_stage_if: SRAM-like instruction request/response port.
//
// Signals
//   inst_req      fetch requests the word at inst_addr
//   inst_addr     request address
//   inst_addr_ok  memory accepts the request (with inst_req)
//   inst_data_ok  response for the oldest outstanding request is on inst_rdata
//   inst_rdata    response data
//
// Modports
//   master  fetch side
//   slave   memory side

interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 2-entry output FIFO.
//
// Purpose
//   Holds the fetch PC, issues requests on an SRAM-like instruction port,
//   buffers returned instructions in order and hands them to decode.
//   Redirects from the back end (ex / eret / tlb_op) clear the buffer and
//   cancel every response still in flight.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   ds_allowin      decode accepts the presented entry this cycle
//   br_op           decode holds a branch, so the transferred entry is a delay slot
//   pipeline_flush  ex / eret / tlb_op redirect requests
//   flush_target    redirect PC, valid while any pipeline_flush field is high
//   predict_taken   BPU predicts taken for the PC being issued
//   predict_target  BPU predicted target
//   inst_if         instruction request/response port (fetch_stage_if.master)
//   fs_to_ds_bus    entry presented to decode
//   dbg_state       fetch FSM state (RUN / HALT after an address error)
//
// Configuration
//   FS_PREDICT_EN   when defined, an accepted request moves the PC to
//                   predict_target if predict_taken; otherwise PC+4 always.
//
// Handshakes
//   Request : accepted on a cycle where inst_req && inst_addr_ok; inst_addr is
//             the PC. Response : inst_data_ok qualifies inst_rdata for the
//             oldest un-answered request; responses return in request order.
//   Decode  : an entry moves when fs_to_ds_bus.valid && ds_allowin.

package fetch_stage_pkg;

    typedef struct packed {
        logic ex;
        logic eret;
        logic tlb_op;
    } pipeline_flush_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic        bd;
        logic [31:0] badvaddr;
        logic        tlb_refill;
    } fs_exception_t;

    typedef struct packed {
        logic          valid;
        logic [31:0]   inst;
        logic [31:0]   pc;
        fs_exception_t exception;
    } fs_to_ds_bus_t;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fs_state_e;

    localparam logic [31:0] FS_RESET_PC = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_ADEL    = 5'h04;

endpackage

module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ds_allowin,
    input  logic            br_op,
    input  pipeline_flush_t pipeline_flush,
    input  logic [31:0]     flush_target,
    input  logic            predict_taken,
    input  logic [31:0]     predict_target,
    fetch_stage_if.master   inst_if,
    output fs_to_ds_bus_t   fs_to_ds_bus,
    output fs_state_e       dbg_state
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ex;
    } fifo_entry_t;

    // Control state
    logic [31:0] pc_q, pc_d;
    fs_state_e   state_q, state_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  out_q, out_d;
    // Stale responses can exceed two when a flush lands while earlier
    // cancelled responses are still pending, hence the extra bit.
    logic [2:0]  cancel_q, cancel_d;

    // Datapath storage (no reset needed)
    fifo_entry_t fifo_q [2];
    fifo_entry_t fifo_d [2];
    logic [31:0] pcq_q [2];
    logic [31:0] pcq_d [2];

    logic        flush;
    logic        pc_aligned;
    logic        fifo_valid;
    logic        pop;
    logic        space_ok;
    logic        req;
    logic        accept;
    logic        resp;
    logic        resp_drop;
    logic        resp_keep;
    logic        adel_push;
    logic        push;
    logic        wr_ptr;
    logic [1:0]  out_after_resp;
    logic [31:0] next_pc;
    fifo_entry_t push_entry;

`ifdef FS_PREDICT_EN
    assign next_pc = predict_taken ? predict_target : pc_q + 32'd4;
`else
    logic unused_predict;
    assign next_pc        = pc_q + 32'd4;
    assign unused_predict = ^{predict_taken, predict_target};
`endif

    always_comb begin
        flush      = |pipeline_flush;
        pc_aligned = (pc_q[1:0] == 2'b00);
        fifo_valid = !reset && (cnt_q != 2'd0) && !flush;
        pop        = fifo_valid && ds_allowin;
        // In-flight requests plus buffered entries, after this cycle's pop,
        // must leave a free slot for every response that can still arrive.
        space_ok   = (({1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop}) < 3'd2);
        req        = !reset && (state_q == FS_RUN) && pc_aligned && space_ok;
        accept     = req && inst_if.inst_addr_ok;
        resp       = !reset && inst_if.inst_data_ok;
        resp_drop  = resp && (cancel_q != 3'd0);
        resp_keep  = resp && (cancel_q == 3'd0);
        // The address-error entry waits for older responses so order holds.
        adel_push  = !reset && (state_q == FS_RUN) && !pc_aligned &&
                     (out_q == 2'd0) && space_ok;
        push       = resp_keep || adel_push;

        push_entry = '0;
        if (resp_keep) begin
            push_entry.inst = inst_if.inst_rdata;
            push_entry.pc   = pcq_q[0];
            push_entry.ex   = 1'b0;
        end else begin
            push_entry.inst = 32'd0;
            push_entry.pc   = pc_q;
            push_entry.ex   = 1'b1;
        end

        out_after_resp = out_q - {1'b0, resp_keep};
        // With two entries buffered the write lands in the slot the pop frees.
        wr_ptr         = rd_ptr_q ^ cnt_q[0];
    end

    // Next-state logic
    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        cancel_d = cancel_q;
        fifo_d   = fifo_q;
        pcq_d    = pcq_q;

        if (flush) begin
            // Every request not yet answered, including one accepted right
            // now, becomes a response to discard.
            pc_d     = flush_target;
            state_d  = FS_RUN;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
            out_d    = 2'd0;
            cancel_d = cancel_q + {1'b0, out_q} + {2'b00, accept} - {2'b00, resp};
        end else begin
            if (accept) begin
                pc_d = next_pc;
            end
            if (adel_push) begin
                state_d = FS_HALT;
            end
            if (resp_drop) begin
                cancel_d = cancel_q - 3'd1;
            end
            if (resp_keep) begin
                pcq_d[0] = pcq_q[1];
            end
            if (accept) begin
                pcq_d[out_after_resp[0]] = pc_q;
            end
            out_d = out_after_resp + {1'b0, accept};
            if (push) begin
                fifo_d[wr_ptr] = push_entry;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= FS_RESET_PC;
            state_q  <= FS_RUN;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            out_q    <= 2'd0;
            cancel_q <= 3'd0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            cancel_q <= cancel_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        pcq_q  <= pcq_d;
    end

    // Outputs
    always_comb begin
        fs_to_ds_bus                      = '0;
        fs_to_ds_bus.valid                = fifo_valid;
        fs_to_ds_bus.inst                 = fifo_q[rd_ptr_q].inst;
        fs_to_ds_bus.pc                   = fifo_q[rd_ptr_q].pc;
        fs_to_ds_bus.exception.ex         = fifo_q[rd_ptr_q].ex;
        fs_to_ds_bus.exception.exccode    = fifo_q[rd_ptr_q].ex ? EXC_ADEL : 5'd0;
        fs_to_ds_bus.exception.bd         = br_op;
        fs_to_ds_bus.exception.badvaddr   = fifo_q[rd_ptr_q].ex ? fifo_q[rd_ptr_q].pc : 32'd0;
        fs_to_ds_bus.exception.tlb_refill = 1'b0;
    end

    assign inst_if.inst_req  = req;
    assign inst_if.inst_addr = pc_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            ds_allowin;
    logic            br_op;
    pipeline_flush_t pipeline_flush;
    logic [31:0]     flush_target;
    logic            predict_taken;
    logic [31:0]     predict_target;
    fs_to_ds_bus_t   fs_to_ds_bus;
    fs_state_e       dbg_state;

    fetch_stage_if inst_if ();

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_op          (br_op),
        .pipeline_flush (pipeline_flush),
        .flush_target   (flush_target),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .inst_if        (inst_if),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- knobs ----------------
    logic            drv_reset;
    logic            drv_allow;
    logic            drv_br;
    pipeline_flush_t drv_flush;
    logic [31:0]     drv_target;
    int              addr_ok_pct;
    int              data_ok_pct;
    logic            hold_resp;
    logic            pred_on;

    assign predict_taken = pred_on && inst_if.inst_req && (inst_if.inst_addr == 32'hBFC0_0010);

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] exp_q [$];
    logic [31:0] pending_q [$];
    logic [31:0] acc_log [$];
    logic [31:0] dl_pc [$];
    int          dl_cyc [$];
    logic [31:0] next_pc;
    logic        halted;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [31:0] pred_tgt;
    int          cyc;
    int          n_xfer;
    int          n_compared;
    int          n_mismatched;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        next_pc    = FS_RESET_PC;
        halted     = 1'b0;
        pred_valid = 1'b0;
    endtask

    // One delivered entry: the stream restarts at the last redirect and
    // proceeds in word steps; a misaligned PC yields one AdEL entry, then nothing.
    task automatic score_xfer();
        dl_pc.push_back(fs_to_ds_bus.pc);
        dl_cyc.push_back(cyc);
        n_xfer++;
        if (halted) begin
            check("no_xfer_after_adel", 32'(fs_to_ds_bus.valid), 32'd0);
        end else begin
            check("xfer_pc", fs_to_ds_bus.pc, next_pc);
            if (next_pc[1:0] != 2'b00) begin
                check("adel_ex", 32'(fs_to_ds_bus.exception.ex), 32'd1);
                check("adel_exccode", 32'(fs_to_ds_bus.exception.exccode), 32'h4);
                check("adel_badvaddr", fs_to_ds_bus.exception.badvaddr, next_pc);
                check("adel_inst", fs_to_ds_bus.inst, 32'd0);
                halted = 1'b1;
            end else begin
                check("xfer_inst", fs_to_ds_bus.inst, mem_word(next_pc));
                check("xfer_ex", 32'(fs_to_ds_bus.exception.ex), 32'd0);
                if (pred_valid && (pred_pc == next_pc)) begin
                    next_pc    = pred_tgt;
                    pred_valid = 1'b0;
                end else begin
                    next_pc = next_pc + 32'd4;
                end
            end
            check("xfer_bd", 32'(fs_to_ds_bus.exception.bd), 32'(br_op));
            check("xfer_tlb_refill", 32'(fs_to_ds_bus.exception.tlb_refill), 32'd0);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle();
        logic flush_now;
        @(negedge clk);
        reset                = drv_reset;
        ds_allowin           = drv_allow;
        br_op                = drv_br;
        pipeline_flush       = drv_flush;
        flush_target         = drv_target;
        inst_if.inst_addr_ok = ($urandom_range(0, 99) < addr_ok_pct);
        if (drv_reset) begin
            inst_if.inst_data_ok = 1'($urandom_range(0, 1));
            inst_if.inst_rdata   = $urandom;
        end else if (!hold_resp && (pending_q.size() > 0) &&
                     ($urandom_range(0, 99) < data_ok_pct)) begin
            inst_if.inst_data_ok = 1'b1;
            inst_if.inst_rdata   = mem_word(pending_q[0]);
        end else begin
            inst_if.inst_data_ok = 1'b0;
            inst_if.inst_rdata   = $urandom;
        end
        #2;
        if (reset) begin
            check("rst_inst_req", 32'(inst_if.inst_req), 32'd0);
            check("rst_valid", 32'(fs_to_ds_bus.valid), 32'd0);
            pending_q.delete();
            model_reset();
        end else begin
            flush_now = |pipeline_flush;
            if (inst_if.inst_data_ok) begin
                void'(pending_q.pop_front());
            end
            if (inst_if.inst_req && inst_if.inst_addr_ok) begin
                pending_q.push_back(inst_if.inst_addr);
                acc_log.push_back(inst_if.inst_addr);
`ifdef FS_PREDICT_EN
                if (predict_taken && !flush_now) begin
                    pred_valid = 1'b1;
                    pred_pc    = inst_if.inst_addr;
                    pred_tgt   = predict_target;
                end
`endif
            end
            if (flush_now) begin
                check("flush_valid", 32'(fs_to_ds_bus.valid), 32'd0);
            end
            if (fs_to_ds_bus.valid && ds_allowin) begin
                score_xfer();
            end
            if (flush_now) begin
                next_pc    = flush_target;
                halted     = 1'b0;
                pred_valid = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic flush_to(input logic [31:0] target);
        drv_flush    = '0;
        drv_flush.ex = 1'b1;
        drv_target   = target;
        cycle();
        drv_flush = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          idx;
        int          n_rand_start;
        logic [31:0] exp_next;
        int          r;

        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        n_xfer       = 0;
        drv_reset    = 1'b1;
        drv_allow    = 1'b1;
        drv_br       = 1'b0;
        drv_flush    = '0;
        drv_target   = 32'd0;
        addr_ok_pct  = 100;
        data_ok_pct  = 100;
        hold_resp    = 1'b0;
        pred_on      = 1'b0;
        predict_target = 32'h8000_1000;
        model_reset();

        // Reset, with junk responses arriving meanwhile
        repeat (3) cycle();
        drv_reset = 1'b0;
        acc_log.delete();
        dl_pc.delete();
        dl_cyc.delete();

        // First request in the cycle after reset
        cycle();
        check("first_req_count", 32'(acc_log.size()), 32'd1);
        if (acc_log.size() >= 1) check("first_req_addr", acc_log[0], FS_RESET_PC);

        // Streaming: one entry per cycle
        repeat (6) cycle();
        exp_q = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
        check("stream_count_ge3", 32'(dl_pc.size() >= 3), 32'd1);
        if (dl_pc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("stream_pc", dl_pc[i], exp_q[i]);
            end
            check("stream_gap1", 32'(dl_cyc[1] - dl_cyc[0]), 32'd1);
            check("stream_gap2", 32'(dl_cyc[2] - dl_cyc[1]), 32'd1);
        end

        // Decode stall for 5 cycles
        drv_allow = 1'b0;
        repeat (5) cycle();
        check("stall_inst_req", 32'(inst_if.inst_req), 32'd0);
        check("stall_valid", 32'(fs_to_ds_bus.valid), 32'd1);
        check("stall_pending", 32'(pending_q.size()), 32'd0);
        check("stall_buffered", 32'(acc_log.size() - n_xfer), 32'd2);
        dl_pc.delete();
        drv_allow = 1'b1;
        cycle();
        cycle();
        check("release_delivered", 32'(dl_pc.size()), 32'd2);

        // Flush with two requests outstanding
        hold_resp = 1'b1;
        repeat (6) cycle();
        check("two_outstanding", 32'(pending_q.size()), 32'd2);
        check("drained_valid", 32'(fs_to_ds_bus.valid), 32'd0);
        flush_to(32'hBFC0_0380);
        hold_resp = 1'b0;
        dl_pc.delete();
        for (int i = 0; i < 30 && dl_pc.size() == 0; i++) cycle();
        check("flush_delivered", 32'(dl_pc.size() > 0), 32'd1);
        if (dl_pc.size() > 0) check("flush_first_pc", dl_pc[0], 32'hBFC0_0380);

        // Misaligned redirect: no request, one AdEL entry
        drv_br = 1'b1;
        flush_to(32'h8000_0002);
        acc_log.delete();
        dl_pc.delete();
        repeat (10) cycle();
        check("adel_no_req", 32'(acc_log.size()), 32'd0);
        check("adel_entries", 32'(dl_pc.size()), 32'd1);
        check("adel_state", 32'(dbg_state), 32'(FS_HALT));

        // Predicted-taken request at 0xBFC00010
        pred_on = 1'b1;
        flush_to(32'hBFC0_0000);
        acc_log.delete();
        idx = -1;
        for (int i = 0; i < 40 && idx < 0; i++) begin
            cycle();
            for (int k = 0; k + 1 < acc_log.size(); k++) begin
                if (acc_log[k] == 32'hBFC0_0010 && idx < 0) idx = k;
            end
        end
        pred_on = 1'b0;
`ifdef FS_PREDICT_EN
        exp_next = 32'h8000_1000;
`else
        exp_next = 32'hBFC0_0014;
`endif
        check("pred_seen", 32'(idx >= 0), 32'd1);
        if (idx >= 0) check("pred_next_addr", acc_log[idx + 1], exp_next);
        repeat (15) cycle();

        // Randomized traffic: handshakes, stalls, flushes, mid-run resets
        drv_br       = 1'b0;
        addr_ok_pct  = 60;
        data_ok_pct  = 50;
        n_rand_start = n_xfer;
        for (int i = 0; i < 2500; i++) begin
            drv_allow = ($urandom_range(0, 99) < 70);
            drv_br    = 1'($urandom_range(0, 1));
            drv_flush = '0;
            drv_reset = 1'b0;
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                drv_reset = 1'b1;
            end else if (r < 30) begin
                drv_flush  = pipeline_flush_t'(3'($urandom_range(1, 7)));
                drv_target = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
                if ($urandom_range(0, 9) == 0) drv_target = drv_target | 32'($urandom_range(1, 3));
            end
            cycle();
        end
        drv_reset = 1'b0;
        drv_flush = '0;
        repeat (10) cycle();
        check("random_progress", 32'((n_xfer - n_rand_start) >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
